fft_frame_collector: RTL and testbench
======================================

Name: fft_frame_collector

Overview:
- Parametrised serial-to-parallel frame collector that feeds the fft_core64 array datapath.
- Successor to the single-frame input gather stage: configurable length and width, ping-pong banks, valid/ready backpressure, explicit start-of-frame resync, optional bit-reversed storage and a sticky overflow flag.
- Sits between the sample source and the parallel FFT core; the core consumes one whole frame per handshake.

Parameters:
- DATA_WID, 16, bits per real/imag sample component.
- FFT_LEN, 64, samples per frame; power of two, 2..1024.
- LOG2_FFT_LEN, 6, log2(FFT_LEN); width of the sample index.
- BIT_REV, 0, 1 = store sample k at frame slot bitrev(k); 0 = store at slot k.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- val_i  in  1  input sample valid.
- sof_i  in  1  start of frame; qualified by val_i.
- fft_data_re_i  in  DATA_WID  real part of sample.
- fft_data_im_i  in  DATA_WID  imaginary part of sample.
- rdy_o  out  1  collector can accept a sample this cycle.
- frm_val_o  out  1  complete frame presented.
- frm_rdy_i  in  1  downstream accepts the frame.
- frm_re_o  out  FFT_LEN*DATA_WID  real frame; slot j occupies bits [j*DATA_WID +: DATA_WID].
- frm_im_o  out  FFT_LEN*DATA_WID  imaginary frame, same packing.
- ovf_o  out  1  sticky: a sample was offered while rdy_o=0.

Behaviour:
- State:
  - two banks, B0 and B1, each holding FFT_LEN re/im pairs;
  - wr_bank, rd_bank, full[1:0], wr_ptr[LOG2_FFT_LEN-1:0], ovf.
- Reset (rst=1, async): wr_bank=0, rd_bank=0, full=0, wr_ptr=0, ovf=0, all bank data=0. Resulting outputs: rdy_o=1, frm_val_o=0, frm_re_o=0, frm_im_o=0, ovf_o=0. A reset mid-frame or mid-handshake discards everything.
- rdy_o = !full[wr_bank] (combinational). A sample is accepted when val_i && rdy_o.
- Write slot = (sof_i ? 0 : wr_ptr), bit-reversed when BIT_REV=1.
- Accept with sof_i=1:
  - sample lands in slot index 0; wr_ptr <= 1;
  - partial data in the current bank is abandoned; stale slots are overwritten before the frame completes.
- Accept with sof_i=0: store at wr_ptr; wr_ptr <= wr_ptr+1.
- Frame completion (accept at index FFT_LEN-1):
  - full[wr_bank] <= 1, wr_bank toggles, wr_ptr <= 0;
  - FFT_LEN=1 is not supported.
- Gaps (val_i=0) do not reset wr_ptr; the frame resumes at the next valid.
- Ignored inputs: sof_i without val_i; samples offered while rdy_o=0.
- Overflow: val_i && !rdy_o sets ovf (sticky until rst); the sample is dropped and wr_ptr is unchanged.
- Output:
  - frm_val_o = full[rd_bank];
  - frm_re_o/frm_im_o = bank rd_bank contents, held stable while frm_val_o=1 and frm_rdy_i=0.
- Handshake: when frm_val_o && frm_rdy_i: full[rd_bank] <= 0 and rd_bank toggles.
- Latency: last sample accepted at edge t → frm_val_o=1 after edge t, provided the bank was empty. Data is unchanged from input, with no scaling.
- Simultaneous frame completion and frame accept: both take effect; rdy_o stays 1 and the next frame presents with no bubble.
- Both banks full: rdy_o=0 until a frame is accepted; rdy_o returns to 1 the cycle after the accepting edge.
- frm_rdy_i while frm_val_o=0: no effect.

Decomposition:
- Shared package/defines file: DATA_WID, FFT_LEN and LOG2_FFT_LEN defaults (existing fft_defines header), plus a bitrev function of width LOG2_FFT_LEN.
- One sub-module: fft_frame_bank, holding a single FFT_LEN-slot re/im register bank with write enable, slot index and packed read-out; instantiated twice. Control (pointers, full flags, overflow) stays in the top.

Test Plan:
- FFT_LEN=8, BIT_REV=0, frm_rdy_i=1; feed re=1..8, im=-1..-8 back-to-back → frm_val_o high one cycle after sample 8; slot j re=j+1, im=-(j+1); rdy_o always 1.
- Same configuration with BIT_REV=1; feed re=0..7 → slots hold 0,4,2,6,1,5,3,7 (slot 1 = 4).
- frm_rdy_i=0; stream 3 frames → first two frames fill B0 then B1; rdy_o drops after sample 16; samples 17+ are dropped and ovf_o=1. Raise frm_rdy_i → frame 1 then frame 2 emerge, each held stable until accepted.
- Feed 5 samples, then sof_i=1 with re=100, then 7 more → the frame emitted has slot 0=100 followed by the 7 new samples; no frame is emitted from the partial data.
- Insert random val_i gaps within a frame → the frame matches the gapless result; gaps do not restart the count.
- Assert rst with one frame pending and 3 samples of the next written → all outputs return to reset values immediately. A subsequent 8-sample frame emits correctly, starting at slot 0.

Source files
------------

// File: rtl/fft_frame_collector_pkg.sv
// Shared defaults and helpers for the FFT frame collector and its register banks.
package fft_frame_collector_pkg;

   localparam int unsigned DATA_WID_DEF     = 16;
   localparam int unsigned FFT_LEN_DEF      = 64;
   localparam int unsigned LOG2_FFT_LEN_DEF = 6;

   // Widest supported sample index (FFT_LEN up to 1024) and the bit-select width into it.
   localparam int unsigned LOG2_LEN_MAX = 10;
   localparam int unsigned LOG2_IDX_W   = 4;

   // Reverse the low 'wid' bits of idx; the bits above wid come back as zero.
   function automatic logic [LOG2_LEN_MAX-1:0] bitrev(
      input logic [LOG2_LEN_MAX-1:0] idx,
      input int unsigned             wid
   );
      logic [LOG2_LEN_MAX-1:0] rev;
      rev = '0;
      for (int unsigned i = 0; i < LOG2_LEN_MAX; i++) begin
         if (i < wid) begin
            rev[LOG2_IDX_W'(i)] = idx[LOG2_IDX_W'(wid - 1 - i)];
         end
      end
      return rev;
   endfunction

endpackage

// File: rtl/fft_frame_collector_bank.sv
// One FFT_LEN-slot re/im register bank: single-slot write port, whole-frame packed read-out.
module fft_frame_collector_bank
   import fft_frame_collector_pkg::*;
#(
   parameter int unsigned DATA_WID     = DATA_WID_DEF,
   parameter int unsigned FFT_LEN      = FFT_LEN_DEF,
   parameter int unsigned LOG2_FFT_LEN = LOG2_FFT_LEN_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [LOG2_FFT_LEN-1:0]      slot,
   input  logic [DATA_WID-1:0]          wr_re,
   input  logic [DATA_WID-1:0]          wr_im,
   output logic [FFT_LEN*DATA_WID-1:0]  frm_re,
   output logic [FFT_LEN*DATA_WID-1:0]  frm_im
);

   logic [DATA_WID-1:0] re_q [FFT_LEN];
   logic [DATA_WID-1:0] im_q [FFT_LEN];

   // Slot storage; only the addressed slot changes on a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(FFT_LEN); i++) begin
            re_q[i] <= '0;
            im_q[i] <= '0;
         end
      end else if (we) begin
         re_q[slot] <= wr_re;
         im_q[slot] <= wr_im;
      end
   end

   for (genvar j = 0; j < int'(FFT_LEN); j++) begin : g_pack
      assign frm_re[j*DATA_WID +: DATA_WID] = re_q[j];
      assign frm_im[j*DATA_WID +: DATA_WID] = im_q[j];
   end

endmodule

// File: rtl/fft_frame_collector.sv
// Serial-to-parallel frame collector with ping-pong banks feeding the parallel FFT core.
module fft_frame_collector
   import fft_frame_collector_pkg::*;
#(
   parameter int unsigned DATA_WID     = DATA_WID_DEF,
   parameter int unsigned FFT_LEN      = FFT_LEN_DEF,
   parameter int unsigned LOG2_FFT_LEN = LOG2_FFT_LEN_DEF,
   parameter int unsigned BIT_REV      = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         val_i,
   input  logic                         sof_i,
   input  logic [DATA_WID-1:0]          fft_data_re_i,
   input  logic [DATA_WID-1:0]          fft_data_im_i,
   output logic                         rdy_o,
   output logic                         frm_val_o,
   input  logic                         frm_rdy_i,
   output logic [FFT_LEN*DATA_WID-1:0]  frm_re_o,
   output logic [FFT_LEN*DATA_WID-1:0]  frm_im_o,
   output logic                         ovf_o
);

   localparam int unsigned PW = LOG2_FFT_LEN;

   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [1:0]    full_q,    full_d;
   logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
   logic          ovf_q,     ovf_d;

   logic          accept;
   logic          last;
   logic          take;
   logic [PW-1:0] idx;
   logic [PW-1:0] slot;

   logic [FFT_LEN*DATA_WID-1:0] b0_re, b0_im, b1_re, b1_im;

   assign rdy_o     = !full_q[wr_bank_q];
   assign frm_val_o = full_q[rd_bank_q];
   assign ovf_o     = ovf_q;
   assign frm_re_o  = rd_bank_q ? b1_re : b0_re;
   assign frm_im_o  = rd_bank_q ? b1_im : b0_im;

   // Sample acceptance and write-slot selection; sof forces the frame back to index 0.
   always_comb begin
      accept = val_i && rdy_o;
      idx    = sof_i ? '0 : wr_ptr_q;
      slot   = (BIT_REV != 0) ? PW'(bitrev(LOG2_LEN_MAX'(idx), PW)) : idx;
      last   = accept && (idx == PW'(FFT_LEN - 1));
      take   = full_q[rd_bank_q] && frm_rdy_i;
   end

   // Pointer, full-flag and overflow next state. A completing write and a frame
   // handshake always target different banks, so both may apply in one cycle.
   always_comb begin
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;
      wr_ptr_d  = wr_ptr_q;
      ovf_d     = ovf_q;

      if (accept) begin
         wr_ptr_d = last ? '0 : idx + PW'(1);
      end
      if (last) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = !wr_bank_q;
      end
      if (take) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end
      if (val_i && !rdy_o) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= '0;
         wr_ptr_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         wr_ptr_q  <= wr_ptr_d;
         ovf_q     <= ovf_d;
      end
   end

   fft_frame_collector_bank #(
      .DATA_WID     (DATA_WID),
      .FFT_LEN      (FFT_LEN),
      .LOG2_FFT_LEN (LOG2_FFT_LEN)
   ) u_bank0 (
      .clk    (clk),
      .rst    (rst),
      .we     (accept && !wr_bank_q),
      .slot   (slot),
      .wr_re  (fft_data_re_i),
      .wr_im  (fft_data_im_i),
      .frm_re (b0_re),
      .frm_im (b0_im)
   );

   fft_frame_collector_bank #(
      .DATA_WID     (DATA_WID),
      .FFT_LEN      (FFT_LEN),
      .LOG2_FFT_LEN (LOG2_FFT_LEN)
   ) u_bank1 (
      .clk    (clk),
      .rst    (rst),
      .we     (accept && wr_bank_q),
      .slot   (slot),
      .wr_re  (fft_data_re_i),
      .wr_im  (fft_data_im_i),
      .frm_re (b1_re),
      .frm_im (b1_im)
   );

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector: natural-order and bit-reversed instances share stimulus.
module tb_fft_frame_collector;

   localparam int unsigned DW = 16;
   localparam int unsigned N  = 8;
   localparam int unsigned LG = 3;
   localparam int unsigned FW = N * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          val, sof, frm_rdy;
   logic [DW-1:0] re, im;

   logic          rdy0, fv0, ovf0, rdy1, fv1, ovf1;
   logic [FW-1:0] fre0, fim0, fre1, fim1;

   int total = 0;
   int bad   = 0;
   logic exp_ovf;

   logic [DW-1:0] er [N];
   logic [DW-1:0] ei [N];

   always #5 clk = ~clk;

   fft_frame_collector #(.DATA_WID(DW), .FFT_LEN(N), .LOG2_FFT_LEN(LG), .BIT_REV(0)) dut0 (
      .clk(clk), .rst(rst), .val_i(val), .sof_i(sof),
      .fft_data_re_i(re), .fft_data_im_i(im),
      .rdy_o(rdy0), .frm_val_o(fv0), .frm_rdy_i(frm_rdy),
      .frm_re_o(fre0), .frm_im_o(fim0), .ovf_o(ovf0)
   );

   fft_frame_collector #(.DATA_WID(DW), .FFT_LEN(N), .LOG2_FFT_LEN(LG), .BIT_REV(1)) dut1 (
      .clk(clk), .rst(rst), .val_i(val), .sof_i(sof),
      .fft_data_re_i(re), .fft_data_im_i(im),
      .rdy_o(rdy1), .frm_val_o(fv1), .frm_rdy_i(frm_rdy),
      .frm_re_o(fre1), .frm_im_o(fim1), .ovf_o(ovf1)
   );

   typedef struct {
      logic          val;
      logic          sof;
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      logic          frdy;
      logic          e_rdy;
      logic          e_fv;
      logic          e_ovf;
   } vec_t;

   vec_t tv [N+1];

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic int br3(input int j);
      return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic s, input logic [DW-1:0] r, input logic [DW-1:0] i);
      val = 1'b1;
      sof = s;
      re  = r;
      im  = i;
      step();
      val = 1'b0;
      sof = 1'b0;
   endtask

   task automatic check_status(input string name, input logic e_rdy, input logic e_fv, input logic e_ovf);
      chk({name, "/rdy0"}, FW'(rdy0), FW'(e_rdy));
      chk({name, "/fv0"},  FW'(fv0),  FW'(e_fv));
      chk({name, "/ovf0"}, FW'(ovf0), FW'(e_ovf));
      chk({name, "/rdy1"}, FW'(rdy1), FW'(e_rdy));
      chk({name, "/fv1"},  FW'(fv1),  FW'(e_fv));
      chk({name, "/ovf1"}, FW'(ovf1), FW'(e_ovf));
   endtask

   // Compares both instances against er/ei given in arrival order.
   task automatic check_frame(input string name);
      logic [FW-1:0] pr0, pi0, pr1, pi1;
      for (int j = 0; j < int'(N); j++) begin
         pr0[j*DW +: DW] = er[j];
         pi0[j*DW +: DW] = ei[j];
         pr1[j*DW +: DW] = er[br3(j)];
         pi1[j*DW +: DW] = ei[br3(j)];
      end
      chk({name, "/re0"}, fre0, pr0);
      chk({name, "/im0"}, fim0, pi0);
      chk({name, "/re1"}, fre1, pr1);
      chk({name, "/im1"}, fim1, pi1);
   endtask

   initial begin
      logic [DW-1:0] lit [N];
      logic [FW-1:0] lit_pk;
      int gaps [N];

      rst = 1'b1; val = 1'b0; sof = 1'b0; re = '0; im = '0; frm_rdy = 1'b0;
      exp_ovf = 1'b0;
      #2;
      check_status("reset", 1'b1, 1'b0, 1'b0);
      chk("reset/re0", fre0, '0);
      chk("reset/im1", fim1, '0);
      step();
      step();
      rst = 1'b0;

      // Back-to-back frame with the consumer always ready
      for (int k = 0; k < int'(N); k++) begin
         tv[k].val   = 1'b1;
         tv[k].sof   = (k == 0);
         tv[k].re    = DW'(k + 1);
         tv[k].im    = DW'(-(k + 1));
         tv[k].frdy  = 1'b1;
         tv[k].e_rdy = 1'b1;
         tv[k].e_fv  = (k == int'(N) - 1);
         tv[k].e_ovf = 1'b0;
         er[k] = DW'(k + 1);
         ei[k] = DW'(-(k + 1));
      end
      tv[N] = '{val: 1'b0, sof: 1'b0, re: '0, im: '0, frdy: 1'b1, e_rdy: 1'b1, e_fv: 1'b0, e_ovf: 1'b0};

      for (int k = 0; k <= int'(N); k++) begin
         val = tv[k].val; sof = tv[k].sof; re = tv[k].re; im = tv[k].im; frm_rdy = tv[k].frdy;
         step();
         check_status($sformatf("vec%0d", k), tv[k].e_rdy, tv[k].e_fv, tv[k].e_ovf);
         if (k == int'(N) - 1) check_frame("vec_frame");
      end
      val = 1'b0; sof = 1'b0;

      // Bit-reversed placement
      lit = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
      for (int j = 0; j < int'(N); j++) lit_pk[j*DW +: DW] = lit[j];
      for (int k = 0; k < int'(N); k++) begin
         send(k == 0, DW'(k), '0);
         er[k] = DW'(k);
         ei[k] = '0;
      end
      check_status("brev", 1'b1, 1'b1, 1'b0);
      chk("brev/literal", fre1, lit_pk);
      check_frame("brev_frame");
      step();
      check_status("brev_take", 1'b1, 1'b0, 1'b0);

      // Backpressure: two frames fill both banks, the third is dropped
      frm_rdy = 1'b0;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < int'(N); k++) begin
            send(k == 0, DW'(256 * (f + 1) + k), DW'(1000 + 10 * f + k));
            if (f == 0 && k == 7) check_status("bp_f1", 1'b1, 1'b1, 1'b0);
            if (f == 1 && k == 6) check_status("bp_s15", 1'b1, 1'b1, 1'b0);
            if (f == 1 && k == 7) check_status("bp_s16", 1'b0, 1'b1, 1'b0);
            if (f == 2 && k == 0) check_status("bp_s17", 1'b0, 1'b1, 1'b1);
         end
      end
      exp_ovf = 1'b1;
      for (int k = 0; k < int'(N); k++) begin
         er[k] = DW'(256 + k);
         ei[k] = DW'(1000 + k);
      end
      check_frame("bp_frame1");
      step();
      step();
      check_frame("bp_frame1_held");
      frm_rdy = 1'b1;
      step();
      frm_rdy = 1'b0;
      check_status("bp_take1", 1'b1, 1'b1, exp_ovf);
      for (int k = 0; k < int'(N); k++) begin
         er[k] = DW'(512 + k);
         ei[k] = DW'(1010 + k);
      end
      check_frame("bp_frame2");
      step();
      check_frame("bp_frame2_held");
      frm_rdy = 1'b1;
      step();
      check_status("bp_take2", 1'b1, 1'b0, exp_ovf);

      // Frame completion coincides with the consumer taking the previous frame
      frm_rdy = 1'b0;
      for (int k = 0; k < int'(N); k++) send(k == 0, DW'(16'h600 + k), DW'(k));
      for (int k = 0; k < int'(N) - 1; k++) send(k == 0, DW'(16'h700 + k), DW'(16'h70 + k));
      frm_rdy = 1'b1;
      send(1'b0, 16'h707, 16'h77);
      frm_rdy = 1'b0;
      check_status("overlap", 1'b1, 1'b1, exp_ovf);
      for (int k = 0; k < int'(N); k++) begin
         er[k] = DW'(16'h700 + k);
         ei[k] = DW'(16'h70 + k);
      end
      check_frame("overlap_frame");
      frm_rdy = 1'b1;
      step();
      check_status("overlap_take", 1'b1, 1'b0, exp_ovf);

      // Start-of-frame resync abandons a partial frame
      for (int k = 0; k < 5; k++) send(k == 0, DW'(50 + k), DW'(2050 + k));
      check_status("sof_partial", 1'b1, 1'b0, exp_ovf);
      send(1'b1, 16'd100, 16'd2100);
      check_status("sof_restart", 1'b1, 1'b0, exp_ovf);
      for (int k = 1; k < int'(N); k++) send(1'b0, DW'(100 + k), DW'(2100 + k));
      check_status("sof_done", 1'b1, 1'b1, exp_ovf);
      for (int k = 0; k < int'(N); k++) begin
         er[k] = DW'(100 + k);
         ei[k] = DW'(2100 + k);
      end
      check_frame("sof_frame");
      step();

      // Idle gaps inside a frame
      gaps = '{0, 2, 0, 1, 3, 0, 0, 0};
      for (int k = 0; k < int'(N); k++) begin
         send(k == 0, DW'(300 + k), DW'(-(300 + k)));
         for (int g = 0; g < gaps[k]; g++) begin
            step();
            check_status($sformatf("gap%0d_%0d", k, g), 1'b1, 1'b0, exp_ovf);
         end
         er[k] = DW'(300 + k);
         ei[k] = DW'(-(300 + k));
      end
      check_status("gap_done", 1'b1, 1'b1, exp_ovf);
      check_frame("gap_frame");
      step();

      // Asynchronous reset with one frame pending and a partial frame in flight
      frm_rdy = 1'b0;
      for (int k = 0; k < int'(N); k++) send(k == 0, DW'(16'h800 + k), DW'(k));
      for (int k = 0; k < 3; k++) send(k == 0, DW'(16'h880 + k), DW'(k));
      check_status("pre_rst", 1'b1, 1'b1, exp_ovf);
      rst = 1'b1;
      #1;
      exp_ovf = 1'b0;
      check_status("async_rst", 1'b1, 1'b0, exp_ovf);
      chk("async_rst/re0", fre0, '0);
      chk("async_rst/im0", fim0, '0);
      chk("async_rst/re1", fre1, '0);
      step();
      rst = 1'b0;
      frm_rdy = 1'b1;
      for (int k = 0; k < int'(N); k++) begin
         send(1'b0, DW'(16'h900 + k), DW'(16'h90 + k));
         er[k] = DW'(16'h900 + k);
         ei[k] = DW'(16'h90 + k);
      end
      check_status("post_rst", 1'b1, 1'b1, exp_ovf);
      check_frame("post_rst_frame");
      step();
      check_status("post_rst_take", 1'b1, 1'b0, exp_ovf);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
